alu_arbiter: RTL

Sequencer and two-requester round-robin arbiter for the shared 16-bit combinational alu (Inp1/Inp2/Opcode -> 32-bit Result). Each requester issues one operation through a valid/ready handshake. The arbiter registers the operands and drives the ALU for a fixed settle window, which covers the mul/div multicycle path. It then captures Result and returns it on one shared response port tagged with the requester id. The block sits between the ALU and its clients, and the ALU itself is instantiated outside.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_arbiter_rr_arb2.sv | 14 +
 rtl/alu_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and width defaults for the ALU arbiter
package alu_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int RES_W_DEF = 32;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT1 = 3'b110;
  localparam logic [2:0] OP_NOT2 = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant whose pointer favours the loser after every accepted grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_q;
  logic ptr_d;
  assign gnt = !en ? 2'b00 : (&req) ? (ptr_q ? 2'b10 : 2'b01) : req;
  assign ptr_d = (|gnt) ? gnt[0] : ptr_q;
  always_ff @(posedge clk) ptr_q <= !rst_n ? 1'b0 : ptr_d;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one combinational ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_inp1,
  input  logic [DATA_W-1:0] req0_inp2,
  input  logic [2:0]        req0_opcode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_inp1,
  input  logic [DATA_W-1:0] req1_inp2,
  input  logic [2:0]        req1_opcode,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  output logic [2:0]        alu_opcode,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  output logic              busy
);
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] inp1_q, inp2_q;
  logic [2:0]        op_q;
  logic              rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [RES_W-1:0]  rsp_result_q;
  logic [1:0]        gnt;
  logic              div0;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == IDLE),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );
  assign div0 = op_q == OP_DIV && inp2_q == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      inp1_q       <= '0;
      inp2_q       <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|gnt) begin
          inp1_q   <= gnt[1] ? req1_inp1 : req0_inp1;
          inp2_q   <= gnt[1] ? req1_inp2 : req0_inp2;
          op_q     <= gnt[1] ? req1_opcode : req0_opcode;
          rsp_id_q <= gnt[1];
          cnt_q    <= 4'(EXEC_CYCLES - 1);
          state_q  <= EXEC;
        end
        EXEC: if (cnt_q == '0) begin
          rsp_result_q <= div0 ? '0 : alu_result;
          rsp_err_q    <= div0;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign alu_inp1   = inp1_q;
  assign alu_inp2   = inp2_q;
  assign alu_opcode = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_result = rsp_result_q;
  assign busy       = state_q != IDLE;
endmodule
